mul_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 64x64 `multiplier` instance among `NUM_REQ` requesters. It owns the multiplier's `op_start`/`op_clear` handshake:
- accepts one request at a time and latches its operands;
- runs the multiplier to `op_done`;
- returns the 128-bit product tagged with the requester index;
- clears the multiplier before the next grant.

A watchdog aborts operations whose `op_done` never arrives.

---
 rtl/mul_arb_pkg.sv | 19 +
 rtl/mul_share_arbiter_rr_picker.sv | 39 +++
 rtl/mul_share_arbiter.sv | 129 ++++++++++++
 tb/tb_mul_share_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mul_arb_pkg : shared widths and FSM encoding for mul_share_arbiter
// Revision    : 1.0
// ---------------------------------------------------------------------------
package mul_arb_pkg;

  localparam int MUL_W  = 64;
  localparam int PROD_W = 128;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    ISSUE = 2'd2,
    WAIT  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mul_share_arbiter_rr_picker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_picker : combinational round-robin search from a start pointer
// Revision  : 1.0
// ---------------------------------------------------------------------------
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     idx,
  output logic               valid
);

  // First pass covers [ptr, NUM_REQ), second pass wraps around from 0.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!valid && req[i] && (i >= int'(ptr))) begin
        valid    = 1'b1;
        idx      = IDW'(i);
        grant[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!valid && req[i]) begin
        valid    = 1'b1;
        idx      = IDW'(i);
        grant[i] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mul_share_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mul_share_arbiter : round-robin sequencer sharing one 64x64 multiplier
// Revision          : 1.0
// ---------------------------------------------------------------------------
module mul_share_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 256,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [MUL_W*NUM_REQ-1:0] req_multiplier,
  input  logic [MUL_W*NUM_REQ-1:0] req_multiplicand,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     rsp_valid,
  output logic [IDW-1:0]           rsp_id,
  output logic [PROD_W-1:0]        rsp_result,
  output logic                     rsp_err,
  output logic                     busy,
  output logic [MUL_W-1:0]         mul_multiplier,
  output logic [MUL_W-1:0]         mul_multiplicand,
  output logic                     mul_op_start,
  output logic                     mul_op_clear,
  input  logic                     mul_op_done,
  input  logic [PROD_W-1:0]        mul_result
);

  localparam int                CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDW-1:0]    ID_LAST  = IDW'(NUM_REQ - 1);

  state_t             r_state;
  logic [IDW-1:0]     r_ptr;
  logic [IDW-1:0]     r_cur_id;
  logic [CNT_W-1:0]   r_wd_cnt;

  logic [NUM_REQ-1:0] w_grant;
  logic [IDW-1:0]     w_idx;
  logic               w_valid;
  logic [MUL_W-1:0]   w_sel_a;
  logic [MUL_W-1:0]   w_sel_b;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_picker (
    .req   (req),
    .ptr   (r_ptr),
    .grant (w_grant),
    .idx   (w_idx),
    .valid (w_valid)
  );

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_a = req_multiplier[i*MUL_W +: MUL_W];
        w_sel_b = req_multiplicand[i*MUL_W +: MUL_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= CLEAR;
      r_ptr            <= '0;
      r_cur_id         <= '0;
      r_wd_cnt         <= '0;
      gnt              <= '0;
      rsp_valid        <= 1'b0;
      rsp_id           <= '0;
      rsp_result       <= '0;
      rsp_err          <= 1'b0;
      busy             <= 1'b1;
      mul_multiplier   <= '0;
      mul_multiplicand <= '0;
      mul_op_start     <= 1'b0;
      mul_op_clear     <= 1'b1;
    end else begin
      gnt       <= '0;
      rsp_valid <= 1'b0;
      case (r_state)
        CLEAR: begin
          r_state      <= IDLE;
          mul_op_clear <= 1'b0;
          busy         <= 1'b0;
        end
        IDLE: begin
          if (w_valid) begin
            r_state          <= ISSUE;
            gnt              <= w_grant;
            r_cur_id         <= w_idx;
            r_ptr            <= (w_idx == ID_LAST) ? '0 : w_idx + 1'b1;
            mul_multiplier   <= w_sel_a;
            mul_multiplicand <= w_sel_b;
            mul_op_start     <= 1'b1;
            busy             <= 1'b1;
          end
        end
        ISSUE: begin
          r_wd_cnt <= '0;
          r_state  <= WAIT;
        end
        WAIT: begin
          r_wd_cnt <= r_wd_cnt + 1'b1;
          // A done arriving on the last watchdog cycle still counts as success.
          if (mul_op_done || (r_wd_cnt == CNT_LAST)) begin
            rsp_valid    <= 1'b1;
            rsp_id       <= r_cur_id;
            rsp_err      <= ~mul_op_done;
            rsp_result   <= mul_op_done ? mul_result : '0;
            mul_op_start <= 1'b0;
            mul_op_clear <= 1'b1;
            r_state      <= CLEAR;
          end
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_share_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mul_share_arbiter : directed bench with a latency-programmable multiplier
// Revision             : 1.0
// ---------------------------------------------------------------------------
module tb_mul_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 16;
  localparam int IDW     = 2;

  logic               clk;
  logic               reset;
  logic [3:0]         req;
  logic [255:0]       req_multiplier;
  logic [255:0]       req_multiplicand;
  logic [3:0]         gnt;
  logic               rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic [127:0]       rsp_result;
  logic               rsp_err;
  logic               busy;
  logic [63:0]        mul_multiplier;
  logic [63:0]        mul_multiplicand;
  logic               mul_op_start;
  logic               mul_op_clear;
  logic               mul_op_done;
  logic [127:0]       mul_result;

  int checks   = 0;
  int failures = 0;
  int lat      = 8;
  int mcnt;
  int rsp_seen  = 0;
  int gnt1_seen = 0;

  mul_share_arbiter #(
    .NUM_REQ (NUM_REQ),
    .TIMEOUT (TIMEOUT),
    .IDW     (IDW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .req              (req),
    .req_multiplier   (req_multiplier),
    .req_multiplicand (req_multiplicand),
    .gnt              (gnt),
    .rsp_valid        (rsp_valid),
    .rsp_id           (rsp_id),
    .rsp_result       (rsp_result),
    .rsp_err          (rsp_err),
    .busy             (busy),
    .mul_multiplier   (mul_multiplier),
    .mul_multiplicand (mul_multiplicand),
    .mul_op_start     (mul_op_start),
    .mul_op_clear     (mul_op_clear),
    .mul_op_done      (mul_op_done),
    .mul_result       (mul_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural multiplier: done after `lat` cycles of op_start.
  always @(posedge clk or posedge reset) begin
    if (reset)                          mcnt <= 0;
    else if (!mul_op_start || mul_op_clear) mcnt <= 0;
    else                                mcnt <= mcnt + 1;
  end
  assign mul_op_done = mul_op_start && (mcnt == lat);
  assign mul_result  = {64'd0, mul_multiplier} * {64'd0, mul_multiplicand};

  always @(posedge clk) begin
    if (rsp_valid) rsp_seen  <= rsp_seen + 1;
    if (gnt[1])    gnt1_seen <= gnt1_seen + 1;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_ops(input int i, input logic [63:0] a, input logic [63:0] b);
    req_multiplier[i*64 +: 64]   = a;
    req_multiplicand[i*64 +: 64] = b;
  endtask

  task automatic wait_gnt(input string tag, output logic [3:0] g);
    g = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (gnt != 4'b0) begin
        g = gnt;
        break;
      end
    end
    check({tag, "_gnt_seen"}, 128'(g != 4'b0), 128'd1);
  endtask

  task automatic wait_rsp(input string tag, output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n = n + 1;
      if (rsp_valid) break;
    end
    check({tag, "_rsp_seen"}, 128'(rsp_valid), 128'd1);
  endtask

  logic [3:0]   g;
  int           n;
  int           snap;
  logic [63:0]  rr_a [4];
  logic [63:0]  rr_b [4];
  logic [127:0] rr_p [4];

  initial begin
    reset            = 1'b1;
    req              = 4'b0;
    req_multiplier   = '0;
    req_multiplicand = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_clear", 128'(mul_op_clear), 128'd1);
    check("rst_busy",  128'(busy),         128'd1);
    check("rst_gnt",   128'(gnt),          128'd0);
    check("rst_valid", 128'(rsp_valid),    128'd0);
    check("rst_start", 128'(mul_op_start), 128'd0);
    check("rst_err",   128'(rsp_err),      128'd0);
    check("rst_res",   rsp_result,         128'd0);
    reset = 1'b0;

    // Round-robin with all requesters active
    rr_a[0] = 64'd3;                  rr_b[0] = 64'd5;
    rr_p[0] = 128'd15;
    rr_a[1] = 64'h10;                 rr_b[1] = 64'h11;
    rr_p[1] = 128'h110;
    rr_a[2] = 64'hFFFF_FFFF_FFFF_FFFF; rr_b[2] = 64'd2;
    rr_p[2] = 128'h1_FFFF_FFFF_FFFF_FFFE;
    rr_a[3] = 64'h1_0000_0000;        rr_b[3] = 64'h1_0000_0000;
    rr_p[3] = 128'h1_0000_0000_0000_0000;
    for (int i = 0; i < 4; i++) set_ops(i, rr_a[i], rr_b[i]);
    lat = 3;
    req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_gnt("rr", g);
      check("rr_gnt",   128'(g),            128'(4'b0001 << (k % 4)));
      check("rr_start", 128'(mul_op_start), 128'd1);
      wait_rsp("rr", n);
      check("rr_id",  128'(rsp_id),  128'(k % 4));
      check("rr_res", rsp_result,    rr_p[k % 4]);
      check("rr_err", 128'(rsp_err), 128'd0);
      if (k == 4) req = 4'b0;
    end

    // Single request from requester 2, latency 8
    lat = 8;
    set_ops(2, 64'h101, 64'h784b);
    req = 4'b0100;
    wait_gnt("single", g);
    check("single_gnt", 128'(g), 128'h4);
    req = 4'b0;
    @(negedge clk);
    check("single_gnt_pulse", 128'(gnt), 128'd0);
    wait_rsp("single", n);
    check("single_lat",   128'(n),            128'd8);
    check("single_id",    128'(rsp_id),       128'd2);
    check("single_res",   rsp_result,         128'h78C34B);
    check("single_err",   128'(rsp_err),      128'd0);
    check("single_clear", 128'(mul_op_clear), 128'd1);
    @(negedge clk);
    check("single_idle_busy", 128'(busy), 128'd0);

    // Watchdog abort
    lat = 1000;
    set_ops(0, 64'd5, 64'd6);
    req = 4'b0001;
    wait_gnt("to", g);
    check("to_gnt", 128'(g), 128'h1);
    req = 4'b0;
    wait_rsp("to", n);
    check("to_lat",   128'(n),            128'd17);
    check("to_err",   128'(rsp_err),      128'd1);
    check("to_res",   rsp_result,         128'd0);
    check("to_id",    128'(rsp_id),       128'd0);
    check("to_clear", 128'(mul_op_clear), 128'd1);
    lat = 4;
    set_ops(3, 64'd7, 64'd9);
    req = 4'b1000;
    wait_gnt("after_to", g);
    check("after_to_gnt", 128'(g), 128'h8);
    req = 4'b0;
    wait_rsp("after_to", n);
    check("after_to_res", rsp_result,    128'd63);
    check("after_to_err", 128'(rsp_err), 128'd0);

    // Done on the final watchdog cycle
    lat = 16;
    set_ops(1, 64'hAB, 64'hCD);
    req = 4'b0010;
    wait_gnt("coin", g);
    check("coin_gnt", 128'(g), 128'h2);
    req = 4'b0;
    wait_rsp("coin", n);
    check("coin_lat", 128'(n),       128'd17);
    check("coin_err", 128'(rsp_err), 128'd0);
    check("coin_res", rsp_result,    128'h88EF);

    // Withdrawal while busy
    lat = 6;
    set_ops(3, 64'h11, 64'h11);
    req = 4'b1000;
    wait_gnt("wd", g);
    check("wd_gnt", 128'(g), 128'h8);
    req  = 4'b0;
    snap = gnt1_seen;
    @(negedge clk);
    req[1] = 1'b1;
    repeat (2) @(negedge clk);
    req[1] = 1'b0;
    wait_rsp("wd", n);
    check("wd_res", rsp_result, 128'h121);
    repeat (3) @(negedge clk);
    check("wd_no_gnt1", 128'(gnt1_seen), 128'(snap));
    set_ops(0, 64'd2, 64'd3);
    req = 4'hF;
    wait_gnt("wd_ptr", g);
    check("wd_ptr_gnt", 128'(g), 128'h1);
    req = 4'b0;
    wait_rsp("wd_ptr", n);
    check("wd_ptr_res", rsp_result, 128'd6);

    // Asynchronous reset in the middle of WAIT
    lat = 1000;
    set_ops(2, 64'hFFFF, 64'hFFFF);
    req = 4'b0100;
    wait_gnt("mrst", g);
    check("mrst_gnt", 128'(g), 128'h4);
    req = 4'b0;
    repeat (3) @(negedge clk);
    snap = rsp_seen;
    #2 reset = 1'b1;
    #1;
    check("mrst_clear", 128'(mul_op_clear),   128'd1);
    check("mrst_busy",  128'(busy),           128'd1);
    check("mrst_start", 128'(mul_op_start),   128'd0);
    check("mrst_res",   rsp_result,           128'd0);
    check("mrst_opa",   128'(mul_multiplier), 128'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    lat = 2;
    repeat (5) @(negedge clk);
    check("mrst_no_rsp", 128'(rsp_seen), 128'(snap));
    req = 4'hF;
    wait_gnt("mrst_ptr", g);
    check("mrst_ptr_gnt", 128'(g), 128'h1);
    req = 4'b0;
    wait_rsp("mrst_ptr", n);
    check("mrst_ptr_id",  128'(rsp_id), 128'd0);
    check("mrst_ptr_res", rsp_result,   128'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
